fpu_demux_nt: RTL
=================

Name: fpu_demux_nt

Overview:
N-target successor of the two-target FPU request demultiplexer. It sits between one core FP offload port and NB_TARGETS FP execution units (APU, FPNEW, DIV/SQRT, ...). Requests are steered by type, and up to MAX_OUTSTANDING requests may be in flight across any mix of targets. An in-order tag FIFO returns responses to the core strictly in issue order. Unknown types complete with an error response instead of hanging the core.

Parameters:
DATA_WIDTH, 32, operand/result width
NB_ARGS, 3, operands per request
OPCODE_WIDTH, 6, opcode width
DSFLAGS_WIDTH, 15, downstream flags width
USFLAGS_WIDTH, 5, upstream (response) flags width
FP_TYPE_WIDTH, 5, type field width
NB_TARGETS, 2, number of target units (1..8)
MAX_OUTSTANDING, 4, order-FIFO depth (power of 2, >=2)
ERR_DATA, 32'hBADF7ACC, rdata returned for unknown type

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
core_slave_req_i  in  1  core request valid
core_slave_gnt_o  out  1  request accepted
core_slave_type_i  in  FP_TYPE_WIDTH  target select
core_slave_operands_i  in  NB_ARGS*DATA_WIDTH  operands
core_slave_op_i  in  OPCODE_WIDTH  opcode
core_slave_flags_i  in  DSFLAGS_WIDTH  flags
core_slave_rready_i  in  1  core ready for response
core_slave_rvalid_o  out  1  response valid
core_slave_rdata_o  out  DATA_WIDTH  result
core_slave_rflags_o  out  USFLAGS_WIDTH  result flags
tgt_req_o  out  NB_TARGETS  per-target request
tgt_gnt_i  in  NB_TARGETS  per-target grant
tgt_operands_o  out  NB_TARGETS*NB_ARGS*DATA_WIDTH  operands, broadcast
tgt_op_o  out  NB_TARGETS*OPCODE_WIDTH  opcode, broadcast
tgt_flags_o  out  NB_TARGETS*DSFLAGS_WIDTH  flags, broadcast
tgt_rready_o  out  NB_TARGETS  per-target response ready
tgt_rvalid_i  in  NB_TARGETS  per-target response valid
tgt_rdata_i  in  NB_TARGETS*DATA_WIDTH  per-target result
tgt_rflags_i  in  NB_TARGETS*USFLAGS_WIDTH  per-target flags
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  entries in order FIFO
err_o  out  1  one-cycle pulse when an error response is popped

Behaviour:
- Clock clk; rst_n is asynchronous, active-low. Reset clears the FIFO pointers and count.
- Outputs in reset and with an empty FIFO: gnt=0, rvalid=0, rdata=0, rflags=0, tgt_req=0, tgt_rready=0, outstanding=0, err=0.
- Request/data payload is broadcast combinationally to all targets. Only tgt_req_o is one-hot.
- Decode: type t < NB_TARGETS selects target t (valid); any other value is an error.
- Valid request, FIFO not full: tgt_req_o[t]=1, core_slave_gnt_o=tgt_gnt_i[t]. On gnt the tag t is pushed.
- Error request, FIFO not full: no tgt_req; gnt=1 the same cycle; an ERR tag is pushed.
- FIFO full: tgt_req_o=0 and gnt=0 regardless of type. There is no push-when-full bypass, even if a pop occurs that cycle.
- Response path is driven only from the FIFO head:
  - Head = target h: rvalid=tgt_rvalid_i[h], rdata/rflags=target h, tgt_rready_o[h]=core_slave_rready_i. All other tgt_rready=0.
  - Head = ERR: rvalid=1, rdata=ERR_DATA, rflags=0.
  - Pop on rvalid && rready. err_o=1 in the cycle an ERR tag pops.
- Latency: a response is presented no earlier than the cycle after its grant. No same-cycle bypass, because the tag is registered.
- Targets must hold rvalid/rdata until rready (valid/ready), including responses produced in the grant cycle.
- Target responses whose tag is not at the head see rready=0 and must wait. Ordering across targets is therefore program order.
- Simultaneous push and pop: both happen; the count is unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o equals the registered count. It never exceeds MAX_OUTSTANDING and never underflows.
- Reset mid-operation: all in-flight tags are discarded. Late target responses are then ignored (rready stays 0 until matching tags exist). System reset of the targets is assumed concurrent.
- Request inputs must stay stable while req=1 and gnt=0; the block does not register them.

Test Plan:
- Single op type=1 (NB_TARGETS=2), tgt_gnt[1]=1; target answers rvalid 3 cycles later with 32'h3F800000 -> core rvalid on that cycle with rdata 32'h3F800000; outstanding goes 1 then 0.
- Issue type=0, type=1, type=0. Target 1 responds first with 32'h11, then target 0 with 32'hA0 and 32'hA1 -> core receives A0, 11, A1 in that order; tgt_rready[1] stays low until the head is tag 1.
- Five back-to-back grants to target 0 with MAX_OUTSTANDING=4 and responses withheld -> 4th gnt accepted, 5th held (gnt=0, tgt_req=0, outstanding=4). One pop lets the 5th be granted the next cycle.
- type=7 -> gnt=1 same cycle; next cycle rvalid=1, rdata=32'hBADF7ACC, rflags=0; err_o pulses on pop; no tgt_req asserted.
- core_slave_rready_i=0 for 5 cycles with a head response valid -> rvalid and rdata stable, no pop; pop on the first rready=1 cycle.
- rst_n asserted with 3 outstanding -> outputs zero immediately (async) and outstanding=0. After release, a new type=0 request completes normally.

Source files
------------

// File: rtl/fpu_demux_nt.sv
// fpu_demux_nt: steers core FP requests to N execution units by type
// and returns their responses in issue order via a tag FIFO.
module fpu_demux_nt #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NB_ARGS         = 3,
  parameter int unsigned OPCODE_WIDTH    = 6,
  parameter int unsigned DSFLAGS_WIDTH   = 15,
  parameter int unsigned USFLAGS_WIDTH   = 5,
  parameter int unsigned FP_TYPE_WIDTH   = 5,
  parameter int unsigned NB_TARGETS      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hBADF7ACC
) (
  input  logic clk,
  input  logic rst_n,

  input  logic core_slave_req_i,
  output logic core_slave_gnt_o,
  input  logic [FP_TYPE_WIDTH-1:0] core_slave_type_i,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] core_slave_operands_i,
  input  logic [OPCODE_WIDTH-1:0] core_slave_op_i,
  input  logic [DSFLAGS_WIDTH-1:0] core_slave_flags_i,
  input  logic core_slave_rready_i,
  output logic core_slave_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_slave_rdata_o,
  output logic [USFLAGS_WIDTH-1:0] core_slave_rflags_o,

  output logic [NB_TARGETS-1:0] tgt_req_o,
  input  logic [NB_TARGETS-1:0] tgt_gnt_i,
  output logic [NB_TARGETS*NB_ARGS*DATA_WIDTH-1:0] tgt_operands_o,
  output logic [NB_TARGETS*OPCODE_WIDTH-1:0] tgt_op_o,
  output logic [NB_TARGETS*DSFLAGS_WIDTH-1:0] tgt_flags_o,
  output logic [NB_TARGETS-1:0] tgt_rready_o,
  input  logic [NB_TARGETS-1:0] tgt_rvalid_i,
  input  logic [NB_TARGETS*DATA_WIDTH-1:0] tgt_rdata_i,
  input  logic [NB_TARGETS*USFLAGS_WIDTH-1:0] tgt_rflags_i,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic err_o
);

  localparam int unsigned IDX_W =
    (NB_TARGETS > 1) ? $clog2(NB_TARGETS) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] idx;
  } tag_t;

  tag_t             mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             type_ok;
  logic [IDX_W-1:0] type_idx;
  tag_t             push_tag;
  tag_t             head;

  assign tgt_operands_o = {NB_TARGETS{core_slave_operands_i}};
  assign tgt_op_o       = {NB_TARGETS{core_slave_op_i}};
  assign tgt_flags_o    = {NB_TARGETS{core_slave_flags_i}};

  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  assign type_ok  = core_slave_type_i < FP_TYPE_WIDTH'(NB_TARGETS);
  assign type_idx = IDX_W'(core_slave_type_i);

  always_comb begin
    push_tag.err = ~type_ok;
    push_tag.idx = type_idx;
  end

  // rst_n gates the request side so nothing is granted during reset
  always_comb begin
    tgt_req_o        = '0;
    core_slave_gnt_o = 1'b0;
    if (rst_n && core_slave_req_i && !full) begin
      if (type_ok) begin
        for (int i = 0; i < NB_TARGETS; i++) begin
          if (type_idx == IDX_W'(i)) begin
            tgt_req_o[i]     = 1'b1;
            core_slave_gnt_o = tgt_gnt_i[i];
          end
        end
      end else begin
        core_slave_gnt_o = 1'b1;
      end
    end
  end

  assign push = core_slave_gnt_o;

  always_comb begin
    core_slave_rvalid_o = 1'b0;
    core_slave_rdata_o  = '0;
    core_slave_rflags_o = '0;
    tgt_rready_o        = '0;
    if (!empty) begin
      if (head.err) begin
        core_slave_rvalid_o = 1'b1;
        core_slave_rdata_o  = ERR_DATA;
      end else begin
        for (int i = 0; i < NB_TARGETS; i++) begin
          if (head.idx == IDX_W'(i)) begin
            core_slave_rvalid_o = tgt_rvalid_i[i];
            core_slave_rdata_o  =
              tgt_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            core_slave_rflags_o =
              tgt_rflags_i[i*USFLAGS_WIDTH +: USFLAGS_WIDTH];
            tgt_rready_o[i]     = core_slave_rready_i;
          end
        end
      end
    end
  end

  assign pop           = core_slave_rvalid_o && core_slave_rready_i;
  assign err_o         = pop && head.err;
  assign outstanding_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
